rpn_evaluator: RTL and testbench

- Parametrised token-stream Reverse Polish Notation evaluator.
- Merges the evaluation stack and the calculator into one block, with configurable data width, stack depth, an iterative divider and explicit error reporting.
- Sits downstream of the infix-to-RPN converter and consumes its operand/operator tokens over a strobe/acknowledge handshake.
- Emits one result, or one error, per expression to a downstream sink.

---
 rtl/rpn_evaluator.sv | 226 ++++++++++++++++++++++
 tb/tb_rpn_evaluator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_evaluator.sv
// Token-stream RPN evaluator: register-array stack, wrapping ALU and a bit-serial restoring divider.
// Emits one result or one error code per expression; the output is held until the sink acknowledges it.
module rpn_evaluator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INPUT_STB,
  input  logic [WIDTH-1:0] INPUT_DAT,
  input  logic             INPUT_IS_OP,
  output logic             INPUT_ACK,
  output logic             OUTPUT_STB,
  output logic [WIDTH-1:0] OUTPUT_DAT,
  output logic [2:0]       OUTPUT_ERR,
  input  logic             OUTPUT_ACK,
  output logic [CW-1:0]    STACK_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH+1);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;
  localparam logic [2:0] OP_DUP = 3'd6;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             ostb_q, ostb_d;
  logic [WIDTH-1:0] odat_q, odat_d;
  logic [2:0]       oerr_q, oerr_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic [SW-1:0]    step_q, step_d;
  logic             mod_q, mod_d;

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_dat;
  logic [2:0]       err_code;

  logic [AW-1:0]    top_idx, sec_idx, push_idx;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       opc;

  assign top_idx  = AW'(cnt_q - CNT_ONE);
  assign sec_idx  = AW'(cnt_q - CNT_TWO);
  assign push_idx = AW'(cnt_q);
  assign op_b     = stk_q[top_idx];
  assign op_a     = stk_q[sec_idx];
  assign opc      = INPUT_DAT[2:0];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_n, quo_n;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign rem_n  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_n  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    ostb_d   = ostb_q;
    odat_d   = odat_q;
    oerr_d   = oerr_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    mod_d    = mod_q;
    wr_en    = 1'b0;
    wr_idx   = top_idx;
    wr_dat   = op_b;
    err_code = 3'd0;
    case (state_q)
      ST_ACCEPT: begin
        if (INPUT_STB && !ack_q) begin
          ack_d = 1'b1;
          if (!INPUT_IS_OP) begin
            if (cnt_q == CNT_FULL) err_code = 3'd1;
            else begin
              wr_en  = 1'b1;
              wr_idx = push_idx;
              wr_dat = INPUT_DAT;
              cnt_d  = cnt_q + CNT_ONE;
            end
          end else begin
            case (opc)
              OP_ADD, OP_SUB, OP_MUL: begin
                if (cnt_q < CNT_TWO) err_code = 3'd2;
                else begin
                  wr_en  = 1'b1;
                  wr_idx = sec_idx;
                  wr_dat = (opc == OP_ADD) ? op_a + op_b :
                           (opc == OP_SUB) ? op_a - op_b : op_a * op_b;
                  cnt_d  = cnt_q - CNT_ONE;
                end
              end
              OP_DIV, OP_MOD: begin
                if (cnt_q < CNT_TWO) err_code = 3'd2;
                else if (op_b == '0) err_code = 3'd3;
                else begin
                  ack_d   = 1'b0;
                  state_d = ST_DIVIDE;
                  dvs_d   = op_b;
                  quo_d   = op_a;
                  rem_d   = '0;
                  step_d  = '0;
                  mod_d   = (opc == OP_MOD);
                end
              end
              OP_NEG: begin
                if (cnt_q == '0) err_code = 3'd2;
                else begin
                  wr_en  = 1'b1;
                  wr_dat = '0 - op_b;
                end
              end
              OP_DUP: begin
                if (cnt_q == '0) err_code = 3'd2;
                else if (cnt_q == CNT_FULL) err_code = 3'd1;
                else begin
                  wr_en  = 1'b1;
                  wr_idx = push_idx;
                  cnt_d  = cnt_q + CNT_ONE;
                end
              end
              default: begin
                if (cnt_q == '0) err_code = 3'd2;
                else begin
                  ostb_d  = 1'b1;
                  odat_d  = op_b;
                  oerr_d  = (cnt_q == CNT_ONE) ? 3'd0 : 3'd4;
                  cnt_d   = '0;
                  state_d = ST_OUTPUT;
                end
              end
            endcase
          end
          if (err_code != 3'd0) begin
            cnt_d   = '0;
            ostb_d  = 1'b1;
            odat_d  = '0;
            oerr_d  = err_code;
            state_d = ST_OUTPUT;
          end
        end
      end
      ST_DIVIDE: begin
        rem_d  = rem_n;
        quo_d  = quo_n;
        step_d = step_q + SW'(1);
        // The final step writes its result directly, keeping DIVIDE at WIDTH cycles.
        if (step_q == SW'(WIDTH-1)) begin
          wr_en   = 1'b1;
          wr_idx  = sec_idx;
          wr_dat  = mod_q ? rem_n : quo_n;
          cnt_d   = cnt_q - CNT_ONE;
          ack_d   = 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      default: begin
        if (ostb_q && OUTPUT_ACK) begin
          ostb_d  = 1'b0;
          state_d = ST_ACCEPT;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_ACCEPT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      ostb_q  <= 1'b0;
      odat_q  <= '0;
      oerr_q  <= 3'd0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      step_q  <= '0;
      mod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      ostb_q  <= ostb_d;
      odat_q  <= odat_d;
      oerr_q  <= oerr_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      step_q  <= step_d;
      mod_q   <= mod_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) stk_q[wr_idx] <= wr_dat;
  end

  assign INPUT_ACK  = ack_q;
  assign OUTPUT_STB = ostb_q;
  assign OUTPUT_DAT = odat_q;
  assign OUTPUT_ERR = oerr_q;
  assign STACK_CNT  = cnt_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Bench for rpn_evaluator: a default-size and a WIDTH=8/DEPTH=4 instance checked against a queue-based RPN model.
module tb_rpn_evaluator;

  localparam logic [31:0] ADD = 0, SUB = 1, MUL = 2, DIV = 3, MOD = 4, NEG = 5, DUP = 6, EMIT = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stb, isop, oack, sel;
  logic [31:0] dat;

  logic        ack0, ostb0;
  logic [31:0] odat0;
  logic [2:0]  oerr0;
  logic [4:0]  cnt0;
  logic        ack1, ostb1;
  logic [7:0]  odat1;
  logic [2:0]  oerr1;
  logic [2:0]  cnt1;

  rpn_evaluator u_big (
    .CLK(clk), .RST(rst),
    .INPUT_STB(stb && !sel), .INPUT_DAT(dat), .INPUT_IS_OP(isop), .INPUT_ACK(ack0),
    .OUTPUT_STB(ostb0), .OUTPUT_DAT(odat0), .OUTPUT_ERR(oerr0), .OUTPUT_ACK(oack && !sel),
    .STACK_CNT(cnt0)
  );

  rpn_evaluator #(.WIDTH(8), .DEPTH(4)) u_small (
    .CLK(clk), .RST(rst),
    .INPUT_STB(stb && sel), .INPUT_DAT(dat[7:0]), .INPUT_IS_OP(isop), .INPUT_ACK(ack1),
    .OUTPUT_STB(ostb1), .OUTPUT_DAT(odat1), .OUTPUT_ERR(oerr1), .OUTPUT_ACK(oack && sel),
    .STACK_CNT(cnt1)
  );

  logic        ack_s, ostb_s;
  logic [31:0] odat_s, oerr_s, cnt_s;
  assign ack_s  = sel ? ack1 : ack0;
  assign ostb_s = sel ? ostb1 : ostb0;
  assign odat_s = sel ? {24'd0, odat1} : odat0;
  assign oerr_s = sel ? {29'd0, oerr1} : {29'd0, oerr0};
  assign cnt_s  = sel ? {29'd0, cnt1} : {27'd0, cnt0};

  int          nvec = 0;
  int          nbad = 0;
  int          W, D;
  logic [31:0] mask;
  logic [31:0] mq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (dut %0d)", tag, got, exp, sel);
    end
  endtask

  task automatic use_dut(input logic s);
    sel  = s;
    W    = s ? 8 : 32;
    D    = s ? 4 : 16;
    mask = s ? 32'hFF : 32'hFFFF_FFFF;
    mq.delete();
  endtask

  // Reference: plain stack-machine semantics on a queue.
  task automatic model_step(input logic is_op, input logic [31:0] v,
                            output logic out, output logic [31:0] od,
                            output logic [2:0] oe, output int lat);
    logic [31:0] a, b, r;
    logic [2:0]  e;
    int          opn;
    out = 1'b0; od = 0; oe = 0; lat = 1; e = 0;
    opn = int'(v[2:0]);
    if (!is_op) begin
      if (mq.size() == D) e = 1;
      else mq.push_back(v & mask);
    end else begin
      case (opn)
        0, 1, 2: begin
          if (mq.size() < 2) e = 2;
          else begin
            b = mq.pop_back();
            a = mq.pop_back();
            r = (opn == 0) ? a + b : (opn == 1) ? a - b : a * b;
            mq.push_back(r & mask);
          end
        end
        3, 4: begin
          if (mq.size() < 2) e = 2;
          else if (mq[$] == 0) e = 3;
          else begin
            b = mq.pop_back();
            a = mq.pop_back();
            r = (opn == 3) ? a / b : a % b;
            mq.push_back(r);
            lat = W + 1;
          end
        end
        5: begin
          if (mq.size() == 0) e = 2;
          else mq[$] = (32'd0 - mq[$]) & mask;
        end
        6: begin
          if (mq.size() == 0) e = 2;
          else if (mq.size() == D) e = 1;
          else mq.push_back(mq[$]);
        end
        default: begin
          if (mq.size() == 0) e = 2;
          else begin
            out = 1'b1;
            od  = mq[$];
            oe  = (mq.size() == 1) ? 3'd0 : 3'd4;
            mq.delete();
          end
        end
      endcase
    end
    if (e != 0) begin
      mq.delete();
      out = 1'b1;
      od  = 0;
      oe  = e;
    end
  endtask

  task automatic send(input logic is_op, input logic [31:0] v, output logic out);
    logic [31:0] od;
    logic [2:0]  oe;
    int          lat, n;
    logic        got;
    model_step(is_op, v, out, od, oe, lat);
    stb = 1'b1; isop = is_op; dat = v;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      got = ack_s;
    end
    stb = 1'b0;
    chk("ack_latency", got ? n : 32'hFFFF_FFFF, lat);
    chk("stack_cnt", cnt_s, mq.size());
    chk("out_stb", {31'd0, ostb_s}, {31'd0, out});
    if (out) begin
      chk("out_dat", odat_s, od);
      chk("out_err", oerr_s, {29'd0, oe});
    end
    @(posedge clk); #1;
    chk("ack_pulse", {31'd0, ack_s}, 0);
  endtask

  task automatic drain();
    oack = 1'b1;
    @(posedge clk); #1;
    oack = 1'b0;
    chk("out_drop", {31'd0, ostb_s}, 0);
  endtask

  task automatic tok(input logic is_op, input logic [31:0] v);
    logic out;
    send(is_op, v, out);
    if (out) drain();
  endtask

  task automatic rand_expr();
    int len;
    len = $urandom_range(1, 8);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 9) < 6)
        tok(1'b0, ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 20));
      else
        tok(1'b1, $urandom_range(0, 6));
    end
    tok(1'b1, EMIT);
  endtask

  initial begin
    logic        out;
    logic [31:0] od;
    logic [2:0]  oe;
    int          lat;

    rst = 1'b1; stb = 1'b0; isop = 1'b0; oack = 1'b0; dat = 0;
    use_dut(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cnt", {27'd0, cnt0}, 0);
    chk("rst_ack", {31'd0, ack0}, 0);
    chk("rst_ostb", {31'd0, ostb0}, 0);
    chk("rst_odat", odat0, 0);
    chk("rst_oerr", {29'd0, oerr0}, 0);
    chk("rst_cnt_s", {29'd0, cnt1}, 0);
    chk("rst_ostb_s", {31'd0, ostb1}, 0);
    chk("rst_odat_s", {24'd0, odat1}, 0);

    // Default-size directed expressions
    tok(0, 3); tok(0, 4); tok(1, ADD); tok(0, 5); tok(1, MUL); tok(1, EMIT);
    tok(0, 100); tok(0, 7); tok(1, DIV); tok(1, EMIT);
    tok(0, 100); tok(0, 7); tok(1, MOD); tok(1, EMIT);

    // Reset in the middle of a divide
    tok(0, 100); tok(0, 7);
    stb = 1'b1; isop = 1'b1; dat = DIV;
    repeat (10) @(posedge clk);
    #1;
    chk("div_busy", {31'd0, ack_s}, 0);
    rst = 1'b1; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    chk("mid_rst_cnt", cnt_s, 0);
    chk("mid_rst_ack", {31'd0, ack_s}, 0);
    chk("mid_rst_ostb", {31'd0, ostb_s}, 0);
    tok(0, 6); tok(1, DUP); tok(1, MUL); tok(1, EMIT);

    // Small instance: overflow, underflow, div-by-zero, unbalanced, wrap
    use_dut(1'b1);
    for (int i = 1; i <= 5; i++) tok(0, i);
    tok(0, 9); tok(1, EMIT);
    tok(1, ADD);
    tok(0, 8); tok(0, 0); tok(1, DIV);
    tok(0, 1); tok(0, 2); tok(1, EMIT);
    tok(0, 200); tok(0, 100); tok(1, ADD); tok(1, EMIT);

    // Output held while the sink stalls, with an input token waiting
    tok(0, 0); tok(1, NEG); tok(0, 1); tok(1, SUB);
    send(1'b1, EMIT, out);
    stb = 1'b1; isop = 1'b0; dat = 9;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_stb", {31'd0, ostb_s}, 1);
      chk("hold_dat", odat_s, 255);
      chk("hold_err", oerr_s, 0);
      chk("hold_noack", {31'd0, ack_s}, 0);
    end
    oack = 1'b1;
    @(posedge clk); #1;
    oack = 1'b0;
    chk("release_drop", {31'd0, ostb_s}, 0);
    chk("release_noack", {31'd0, ack_s}, 0);
    @(posedge clk); #1;
    chk("release_ack", {31'd0, ack_s}, 1);
    stb = 1'b0;
    model_step(1'b0, 9, out, od, oe, lat);
    chk("release_cnt", cnt_s, mq.size());
    @(posedge clk); #1;
    tok(1, EMIT);

    // Randomized expressions on both instances
    use_dut(1'b0);
    repeat (25) rand_expr();
    use_dut(1'b1);
    repeat (40) rand_expr();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
